// File: rtl/host_write_decoder.sv
// rtl/host_write_decoder.sv - MCU byte-write decoder assembling 48/20/16-bit register words
//
// Ports:
//   Clock        system clock
//   Reset        synchronous, active-high
//   Host_Data    MCU data byte (asynchronous)
//   Host_WR_n    MCU write strobe, active-low; byte taken on its rising edge (asynchronous)
//   Host_AD      1 = address byte, 0 = data byte (asynchronous)
//   Data48B_out  48-bit register data bus
//   Data20B_out  20-bit register data bus
//   Data16B_out  16-bit register data bus
//   EN_Vector    one-hot load strobes, index = register address
//   Busy         high while a transfer is being collected or committed
//   Seq_Err      one-cycle pulse on a protocol error or timeout
module host_write_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  Host_Data,
    input  logic        Host_WR_n,
    input  logic        Host_AD,
    output logic [47:0] Data48B_out,
    output logic [19:0] Data20B_out,
    output logic [15:0] Data16B_out,
    output logic [21:0] EN_Vector,
    output logic        Busy,
    output logic        Seq_Err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_COMMIT
    } state_t;

    localparam logic [15:0] LP_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Number of data bytes carried by each register address; 0 marks an invalid address.
    function automatic logic [2:0] f_byte_count(input logic [7:0] addr);
        case (addr)
            8'd0, 8'd1, 8'd2, 8'd3, 8'd6, 8'd7,
            8'd8, 8'd9, 8'd10, 8'd12:               f_byte_count = 3'd6;
            8'd4:                                   f_byte_count = 3'd3;
            8'd5, 8'd11, 8'd13, 8'd14, 8'd15, 8'd16,
            8'd17, 8'd18, 8'd19, 8'd20, 8'd21:      f_byte_count = 3'd2;
            default:                                f_byte_count = 3'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_ad_sync;
    logic [7:0]             r_data_sync [SYNC_STAGES];
    logic                   r_wr_prev;

    // The strobe chain resets to its idle (high) level so that releasing
    // reset with WR_n high does not look like a rising edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_sync <= '1;
            r_ad_sync <= '0;
            r_wr_prev <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= 8'd0;
            end
        end else begin
            r_wr_sync      <= {r_wr_sync[SYNC_STAGES-2:0], Host_WR_n};
            r_ad_sync      <= {r_ad_sync[SYNC_STAGES-2:0], Host_AD};
            r_wr_prev      <= r_wr_sync[SYNC_STAGES-1];
            r_data_sync[0] <= Host_Data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_data_sync[i] <= r_data_sync[i-1];
            end
        end
    end

    logic       w_strobe;
    logic       w_ad;
    logic [7:0] w_data;

    assign w_strobe = ~r_wr_prev & r_wr_sync[SYNC_STAGES-1];
    assign w_ad     = r_ad_sync[SYNC_STAGES-1];
    assign w_data   = r_data_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Transfer FSM
    // ------------------------------------------------------------------
    state_t      r_state;
    logic [7:0]  r_addr;
    logic [2:0]  r_count;
    logic [47:0] r_shift;
    logic [15:0] r_tmo;
    logic [47:0] r_data48;
    logic [19:0] r_data20;
    logic [15:0] r_data16;
    logic [21:0] r_en;
    logic        r_busy;
    logic        r_seq_err;

    // A strobe seen during COMMIT is parked here and replayed in IDLE.
    logic        r_pend;
    logic        r_pend_ad;
    logic [7:0]  r_pend_data;

    logic        w_ev;
    logic        w_ev_ad;
    logic [7:0]  w_ev_data;
    logic [2:0]  w_ev_count;
    logic [47:0] w_shift_next;

    assign w_ev         = w_strobe | r_pend;
    assign w_ev_ad      = r_pend ? r_pend_ad : w_ad;
    assign w_ev_data    = r_pend ? r_pend_data : w_data;
    assign w_ev_count   = f_byte_count(w_ev_data);
    assign w_shift_next = {r_shift[39:0], w_data};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_addr      <= 8'd0;
            r_count     <= 3'd0;
            r_shift     <= 48'd0;
            r_tmo       <= 16'd0;
            r_data48    <= 48'd0;
            r_data20    <= 20'd0;
            r_data16    <= 16'd0;
            r_en        <= 22'd0;
            r_busy      <= 1'b0;
            r_seq_err   <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_ad   <= 1'b0;
            r_pend_data <= 8'd0;
        end else begin
            r_en      <= 22'd0;
            r_seq_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_pend <= 1'b0;
                    r_busy <= 1'b0;
                    if (w_ev) begin
                        if (w_ev_ad && (w_ev_count != 3'd0)) begin
                            r_addr  <= w_ev_data;
                            r_count <= w_ev_count;
                            r_shift <= 48'd0;
                            r_tmo   <= 16'd0;
                            r_busy  <= 1'b1;
                            r_state <= S_COLLECT;
                        end else begin
                            r_seq_err <= 1'b1;
                        end
                    end
                end

                S_COLLECT: begin
                    if (w_strobe && w_ad) begin
                        // Restart: the partial word is dropped silently.
                        if (w_ev_count != 3'd0) begin
                            r_addr  <= w_data;
                            r_count <= w_ev_count;
                            r_shift <= 48'd0;
                            r_tmo   <= 16'd0;
                        end else begin
                            r_seq_err <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end else if (w_strobe) begin
                        r_shift <= w_shift_next;
                        r_tmo   <= 16'd0;
                        if (r_count == 3'd1) begin
                            // Last byte: bus is written now, enable follows one cycle later.
                            case (f_byte_count(r_addr))
                                3'd6:    r_data48 <= w_shift_next;
                                3'd3:    r_data20 <= w_shift_next[19:0];
                                default: r_data16 <= w_shift_next[15:0];
                            endcase
                            r_state <= S_COMMIT;
                        end else begin
                            r_count <= r_count - 3'd1;
                        end
                    end else if (r_tmo == LP_TMO_LAST) begin
                        r_seq_err <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
                    end
                end

                S_COMMIT: begin
                    r_en    <= 22'd1 << r_addr[4:0];
                    r_busy  <= 1'b1;
                    r_state <= S_IDLE;
                    if (w_strobe) begin
                        r_pend      <= 1'b1;
                        r_pend_ad   <= w_ad;
                        r_pend_data <= w_data;
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Data48B_out = r_data48;
    assign Data20B_out = r_data20;
    assign Data16B_out = r_data16;
    assign EN_Vector   = r_en;
    assign Busy        = r_busy;
    assign Seq_Err     = r_seq_err;

endmodule

// File: doc/host_write_decoder.md
Name: host_write_decoder

Overview:
- Front end of the register-load path: takes byte writes from the front-panel MCU parallel bus and assembles them into 48/20/16-bit words.
- Drives the shared data buses and a one-hot enable vector into the latch data region: the DDFS K1/K2, FSK/burst, FM, sweep, delay, DAC and key-data registers.
- Synchronises the asynchronous MCU strobe into the 107 MHz Clock domain and sequences address byte, data bytes, then commit.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on Host_WR_n, Host_AD and Host_Data (min 2).
- TIMEOUT_CYCLES, 50000, Clock cycles allowed between bytes in COLLECT before abort (16-bit counter, max 65535).

Ports:
- Clock  in  1  system clock, 107 MHz.
- Reset  in  1  synchronous, active-high.
- Host_Data  in  8  MCU data byte, asynchronous.
- Host_WR_n  in  1  MCU write strobe, active-low, asynchronous; a byte is taken on its rising edge.
- Host_AD  in  1  1 = address byte, 0 = data byte; asynchronous, stable around the strobe.
- Data48B_out  out  48  to Data48B_in.
- Data20B_out  out  20  to Data20B_in.
- Data16B_out  out  16  to Data16B_in.
- EN_Vector  out  22  one-hot load strobes, index = register address.
- Busy  out  1  high while in COLLECT or COMMIT.
- Seq_Err  out  1  one-cycle pulse on a protocol error.

Behaviour:
- Clock and reset: one clock, Clock. Reset is synchronous and active-high and overrides everything. On reset:
  - all data outputs = 0, EN_Vector = 0, Busy = 0, Seq_Err = 0;
  - FSM goes to IDLE; synchroniser, byte counter and timeout counter are cleared.
- Synchronisation:
  - Host_WR_n, Host_AD and Host_Data each pass through SYNC_STAGES flops.
  - Edge detect: synced WR_n was 0 last cycle and is 1 now. The cycle this is true is the strobe cycle E.
  - AD and data are sampled from their synced copies at E.
- Address map and byte counts:
  - 48-bit class, 6 bytes: 0 K1, 1 K2, 2 FSK interval (bits [41:0] used downstream), 3 burst interval, 6 FM deviation, 7 FM frequency, 8 sweep start/end difference, 9 sweep start, 10 sweep time, 12 burst delay (bits [33:0] used downstream).
  - 20-bit class, 3 bytes: 4 burst count. The upper nibble of the first byte is discarded.
  - 16-bit class, 2 bytes: 5 burst increment, 11 sweep marker, 13 mod wave, 14 DC offset, 15 duty, 16 gain, 17 spare, 18 SQ VL, 19 SQ VT, 20 AM constant, 21 key data.
  - Addresses 22..255 are invalid.
- FSM states: IDLE, COLLECT, COMMIT.
- IDLE:
  - Address byte with a valid address: latch the address, load the byte count for its class, clear the shift register, go to COLLECT.
  - Address byte with an invalid address: pulse Seq_Err, stay in IDLE.
  - Data byte: pulse Seq_Err, ignore the byte.
- COLLECT:
  - Data byte: shift in MSB first (shift = {shift[39:0], byte}), decrement the count, reset the timeout counter. When the count reaches 0, go to COMMIT.
  - Address byte: abort the current transfer with no enable pulse and no Seq_Err, then process the byte exactly as in IDLE (restart).
  - Timeout counter reaching TIMEOUT_CYCLES with no strobe: pulse Seq_Err, go to IDLE, no enable pulse.
- COMMIT (one cycle; last data byte at E):
  - E+1: only the class bus for the latched address is written from the low bits of the shift register; the other buses keep their values.
  - E+2: EN_Vector[address] = 1 for exactly one cycle, FSM returns to IDLE.
  - A strobe arriving during COMMIT is handled in IDLE on the following cycle; strobes cannot be closer than SYNC_STAGES + 1 cycles.
- Bus hold: data buses change only at a COMMIT, so they are stable for the whole enable cycle and afterwards.
- Invariant: EN_Vector is never multi-hot.
- Busy is high from the cycle after an accepted address byte through the enable-pulse cycle.
- Reset mid-transfer: the partial word is discarded and no enable is issued.

Test Plan:
- Reset held 3 cycles, then released -> all outputs 0, FSM in IDLE, Busy = 0.
- Address 0x00, then data 01 23 45 67 89 AB -> Data48B_out = 48'h0123456789AB at E+1; EN_Vector = 22'h000001 for one cycle at E+2; Data20B_out and Data16B_out unchanged.
- Address 0x04, then data FA BC DE -> Data20B_out = 20'hABCDE (nibble F dropped), EN_Vector bit 4 for one cycle. Address 0x15, then data 12 34 -> Data16B_out = 16'h1234, EN_Vector bit 21.
- Address 0x07, data 11 22, then address 0x0D, data 0F FF -> no bit-7 pulse, no Seq_Err; Data16B_out = 16'h0FFF, EN_Vector bit 13.
- Address 0x30 -> Seq_Err one cycle, no enable. Data byte while IDLE -> Seq_Err. Address 0x01, one data byte, then silence for TIMEOUT_CYCLES -> Seq_Err, no enable, Busy falls.
- Address 0x06, 3 data bytes, Reset asserted one cycle -> no enable. A following full 6-byte write to 0x06 -> loads correctly, EN_Vector bit 6 pulses.
